drink_fsm: RTL and testbench
============================

Name: drink_fsm

Overview:
- Synchronous vending-machine controller for a single drink priced at 1.5 yuan.
- Accepts one coin event per clock cycle (0.5 yuan, 1 yuan or a refund request) and tracks the credit inserted so far.
- Dispenses one drink when credit reaches or exceeds the price, returning any change in 0.5-yuan units.
- Standalone leaf block, driven directly by the coin-acceptor front end.

Parameters:
- None. Price fixed at 3 units; 1 unit = 0.5 yuan.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising clk edge.
- coin  input  2  coin event this cycle: 2'b00 none, 2'b01 0.5 yuan, 2'b10 1 yuan, 2'b11 refund request.
- drink  output  1  registered one-cycle pulse; 1 = dispense one drink.
- back  output  2  registered amount returned this cycle, in 0.5-yuan units (0..2).

Behaviour:
- Credit state machine with three states: S0 (credit 0), S1 (credit 0.5 yuan), S2 (credit 1.0 yuan). Credit never rests at 1.5 or more.
- coin is sampled at every rising clk edge when reset=1. drink and back are registered: they reflect the coin sampled at that edge and hold for exactly one cycle. Latency is 1 edge.
- Transitions, written as state/coin -> next state, drink, back:
  - S0/00 -> S0, 0, 0
  - S0/01 -> S1, 0, 0
  - S0/10 -> S2, 0, 0
  - S0/11 -> S0, 0, 0 (refund of nothing)
  - S1/00 -> S1, 0, 0
  - S1/01 -> S2, 0, 0
  - S1/10 -> S0, 1, 0 (exact payment)
  - S1/11 -> S0, 0, 1
  - S2/00 -> S2, 0, 0
  - S2/01 -> S0, 1, 0
  - S2/10 -> S0, 1, 1 (0.5 yuan change)
  - S2/11 -> S0, 0, 2
- On any edge not listed as asserting them, drink=0 and back=0. Outputs are never held high beyond one cycle.
- back never exceeds 2. The value 3 is unreachable and must never appear.
- drink=1 and back=2 never occur together.
- Reset: at a rising edge with reset=0, state becomes S0 and drink=0, back=0. This overrides any coin present in the same cycle; that coin is discarded and no refund is issued. Credit held at reset time is lost.
- Reset mid-pulse: if reset is asserted on the edge after a drink/back pulse began, outputs go to 0 at that edge, as normal.
- Back-to-back purchases are allowed. Credit goes to S0 on the dispense edge, and the next coin is accepted on the very next edge.
- The block assumes clean single-cycle coin events; no debouncing is required.
- Before the first reset edge, state and output values are don't-care. The bench must apply reset first.

Test Plan:
- Reset: hold reset=0 for 2 edges with coin=2'b10 -> drink=0, back=0, state S0. After release, coin=00 for 3 cycles -> outputs stay 0.
- Exact payment: 10 then 01 -> after the 2nd edge drink=1, back=0 for one cycle, then 0/0. Repeat with 01,01,01 -> drink=1, back=0 after the 3rd coin.
- Overpay: 01,01,10 -> no drink after edge 2; drink=1, back=1 after edge 3. Also 10,10 -> drink=1, back=1.
- Refunds: 10,11 -> drink=0, back=2. 01,11 -> back=1. 11 from S0 -> back=0. All pulses last one cycle and return credit to S0; a following 10,01 buys normally.
- Reset mid-credit: 10, then reset=0 with coin=01, then release, then 11 -> back=0 (credit cleared), no drink at any point.
- Back-to-back: 10,10,10,01 with no idle cycles -> drink pulses after the 2nd coin (back=1) and after the 4th coin (back=0); drink=0 in between.

Source files
------------

// File: rtl/drink_fsm.sv
// Vending controller for a 1.5-yuan drink: tracks credit in 0.5-yuan units and
// issues registered one-cycle drink/change pulses.
module drink_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] coin,
  output logic       drink,
  output logic [1:0] back
);

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_HALF = 2'b01;
  localparam logic [1:0] C_ONE  = 2'b10;
  localparam logic [1:0] C_REF  = 2'b11;

  logic [1:0] state, state_nxt;
  logic       drink_nxt;
  logic [1:0] back_nxt;

  always_comb begin
    state_nxt = state;
    drink_nxt = 1'b0;
    back_nxt  = 2'd0;
    case (state)
      S0: begin
        case (coin)
          C_HALF:  state_nxt = S1;
          C_ONE:   state_nxt = S2;
          default: state_nxt = S0;
        endcase
      end
      S1: begin
        case (coin)
          C_NONE: state_nxt = S1;
          C_HALF: state_nxt = S2;
          C_ONE: begin
            state_nxt = S0;
            drink_nxt = 1'b1;
          end
          C_REF: begin
            state_nxt = S0;
            back_nxt  = 2'd1;
          end
          default: state_nxt = S1;
        endcase
      end
      S2: begin
        case (coin)
          C_NONE: state_nxt = S2;
          C_HALF: begin
            state_nxt = S0;
            drink_nxt = 1'b1;
          end
          C_ONE: begin
            state_nxt = S0;
            drink_nxt = 1'b1;
            back_nxt  = 2'd1;
          end
          C_REF: begin
            state_nxt = S0;
            back_nxt  = 2'd2;
          end
          default: state_nxt = S2;
        endcase
      end
      // Encoding 2'b11 is unreachable; recover to empty credit.
      default: state_nxt = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S0;
      drink <= 1'b0;
      back  <= 2'd0;
    end else begin
      state <= state_nxt;
      drink <= drink_nxt;
      back  <= back_nxt;
    end
  end

endmodule

// File: tb/tb_drink_fsm.sv
// Scoreboarded bench for drink_fsm: a credit-arithmetic model pushes expected
// {drink,back} per edge; each scenario task pops and compares after the edge.
module tb_drink_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] coin;
  logic       drink;
  logic [1:0] back;

  int checks = 0;
  int passed = 0;
  int credit = 0;
  logic [2:0] sb[$];

  drink_fsm dut (
    .clk  (clk),
    .reset(reset),
    .coin (coin),
    .drink(drink),
    .back (back)
  );

  always #5 clk = ~clk;

  // Drive one coin/reset pair for one edge; the model predicts the result.
  task automatic drive(input logic [1:0] c, input logic r, output logic [2:0] obs);
    logic       ed;
    int         eb;
    int         sum;
    @(negedge clk);
    coin  = c;
    reset = r;
    ed = 1'b0;
    eb = 0;
    if (!r) begin
      credit = 0;
    end else if (c == 2'b11) begin
      eb = credit;
      credit = 0;
    end else begin
      sum = credit + ((c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0);
      if (sum >= 3) begin
        ed = 1'b1;
        eb = sum - 3;
        credit = 0;
      end else begin
        credit = sum;
      end
    end
    sb.push_back({ed, eb[1:0]});
    @(posedge clk);
    #1;
    obs = {drink, back};
  endtask

  task automatic test_reset;
    logic [2:0] obs, exp;
    for (int i = 0; i < 5; i++) begin
      drive((i < 2) ? 2'b10 : 2'b00, (i < 2) ? 1'b0 : 1'b1, obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL reset[%0d] got drink=%b back=%0d, want drink=%b back=%0d",
                 i, obs[2], obs[1:0], exp[2], exp[1:0]);
      else passed++;
    end
  endtask

  task automatic test_exact;
    logic [1:0] seq [7] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [2:0] obs, exp;
    for (int i = 0; i < 7; i++) begin
      drive(seq[i], 1'b1, obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL exact[%0d] got drink=%b back=%0d, want drink=%b back=%0d",
                 i, obs[2], obs[1:0], exp[2], exp[1:0]);
      else passed++;
      if (i == 1 || i == 5) begin
        checks++;
        if (obs !== 3'b100) $display("FAIL exact_pulse[%0d] got %b want 100", i, obs);
        else passed++;
      end
    end
  endtask

  task automatic test_overpay;
    logic [1:0] seq [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
    logic [2:0] obs, exp;
    for (int i = 0; i < 6; i++) begin
      drive(seq[i], 1'b1, obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL overpay[%0d] got drink=%b back=%0d, want drink=%b back=%0d",
                 i, obs[2], obs[1:0], exp[2], exp[1:0]);
      else passed++;
      if (i == 2 || i == 4) begin
        checks++;
        if (obs !== 3'b101) $display("FAIL overpay_change[%0d] got %b want 101", i, obs);
        else passed++;
      end
    end
  endtask

  task automatic test_refund;
    logic [1:0] seq [9] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    logic [2:0] obs, exp;
    for (int i = 0; i < 9; i++) begin
      drive(seq[i], 1'b1, obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL refund[%0d] got drink=%b back=%0d, want drink=%b back=%0d",
                 i, obs[2], obs[1:0], exp[2], exp[1:0]);
      else passed++;
      if (i == 1) begin
        checks++;
        if (obs !== 3'b010) $display("FAIL refund_full got %b want 010", obs);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_credit;
    logic [1:0] seq [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    logic       rs  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] obs, exp;
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], rs[i], obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL reset_mid[%0d] got drink=%b back=%0d, want drink=%b back=%0d",
                 i, obs[2], obs[1:0], exp[2], exp[1:0]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_pulse;
    logic [2:0] obs, exp;
    drive(2'b10, 1'b1, obs); exp = sb.pop_front();
    drive(2'b10, 1'b1, obs); exp = sb.pop_front();
    checks++;
    if (obs !== exp) $display("FAIL pulse_start got %b want %b", obs, exp);
    else passed++;
    drive(2'b10, 1'b0, obs); exp = sb.pop_front();
    checks++;
    if (obs !== exp) $display("FAIL pulse_reset got %b want %b", obs, exp);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [1:0] seq [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    logic [2:0] obs, exp;
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b1, obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp)
        $display("FAIL b2b[%0d] got drink=%b back=%0d, want drink=%b back=%0d",
                 i, obs[2], obs[1:0], exp[2], exp[1:0]);
      else passed++;
    end
  endtask

  // Random stream: model-checked, plus the illegal-output invariants.
  task automatic test_random;
    logic [2:0] obs, exp;
    for (int i = 0; i < 200; i++) begin
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 19) != 0), obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || obs[1:0] == 2'd3 || obs == 3'b110)
        $display("FAIL random[%0d] got drink=%b back=%0d, want drink=%b back=%0d",
                 i, obs[2], obs[1:0], exp[2], exp[1:0]);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b0;
    coin  = 2'b00;
    test_reset();
    test_exact();
    test_overpay();
    test_refund();
    test_reset_mid_credit();
    test_reset_mid_pulse();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
